instr_fetch_mem: RTL

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_mem_pkg.sv | 15 +
 rtl/instr_mem_array.sv | 24 ++
 rtl/instr_fetch_mem.sv | 111 +++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and default geometry for the instruction fetch memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fetch_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = '0;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port, no reset.
module instr_mem_array #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds the last fetched word between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a one-cycle-latency fetch port and IDLE/LOAD/RUN control.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_req,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic              addr_err,
  output logic              loaded,
  output logic [ADDR_W:0]   prog_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  fetch_state_t      state;
  logic              rsp_valid;
  logic              rsp_nop;
  logic              has_data;
  logic [DATA_W-1:0] mem_rdata;

  logic prog_in_range;
  logic fetch_in_range;
  logic wr_en;
  logic fetch_acc;

  assign prog_in_range  = ({1'b0, prog_addr}  < DEPTH_L);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
  assign wr_en     = !rst && (state == LOAD) && prog_we && prog_in_range;
  assign fetch_acc = !rst && (state == RUN) && fetch_req;

  instr_mem_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (prog_addr[IDX_W-1:0]),
    .wdata (prog_data),
    .re    (fetch_acc && fetch_in_range),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // The response stage is decoupled from the state, so a fetch accepted while
  // leaving RUN still answers on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      loaded     <= 1'b0;
      prog_count <= '0;
      rsp_valid  <= 1'b0;
      rsp_nop    <= 1'b0;
      has_data   <= 1'b0;
    end else begin
      rsp_valid <= fetch_acc;
      if (fetch_acc) begin
        has_data <= 1'b1;
        rsp_nop  <= !fetch_in_range;
      end
      case (state)
        IDLE: begin
          if (prog_req) begin
            state      <= LOAD;
            prog_count <= '0;
          end
        end
        LOAD: begin
          if (wr_en && (prog_count < DEPTH_L)) prog_count <= prog_count + (ADDR_W+1)'(1);
          if (prog_done) begin
            state  <= RUN;
            loaded <= 1'b1;
          end
        end
        RUN: begin
          if (prog_req) begin
            state      <= LOAD;
            prog_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fetch_ready = (state == RUN);
  assign instr_valid = rsp_valid;
  assign addr_err    = rsp_valid && rsp_nop;

  // Before any fetch after reset the array output is meaningless, so show zero.
  always_comb begin
    instr_data = '0;
    if (has_data) instr_data = rsp_nop ? NOP_WORD : mem_rdata;
  end

endmodule
